// File: rtl/cmd_seq_player.sv
// cmd_seq_player: plays a queue of 16-bit commands to RemoteComm one at a time,
// waiting after each for an acknowledge byte under a per-response timeout.
// Optional feature macro CMD_SEQ_RETRY_EN: resend each failing command once before failing.
module cmd_seq_player #(
  parameter int         DEPTH = 8,
  parameter int         TMO_W = 24,
  parameter logic [7:0] ACK   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_vld,
  input  logic [15:0]              ld_cmd,
  output logic                     ld_rdy,
  input  logic                     start,
  input  logic                     abort,
  input  logic [TMO_W-1:0]         tmo_lim,
  output logic [15:0]              cmd,
  output logic                     snd_cmd,
  input  logic                     cmd_snt,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               err,
  output logic [$clog2(DEPTH)-1:0] fail_idx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_TMO   = 2'd1;
  localparam logic [1:0] ERR_NACK  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_SNT, WAIT_RESP, NEXT, FIN
  } state_t;

  state_t           state_q;
  logic [15:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    qcnt_q;
  logic [PW-1:0]    pop_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] lim_q;

  logic [15:0]      cmd_q;
  logic             snd_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [1:0]       err_q;
  logic [PW-1:0]    fail_idx_q;

  logic             wr_en_d;
  logic [PW-1:0]    rd_ptr_inc_d;
  logic             retry_ok_d;

`ifdef CMD_SEQ_RETRY_EN
  logic             retry_q;
  // A command may be resent once; the flag clears when the command is popped
  assign retry_ok_d = ~retry_q;
`else
  assign retry_ok_d = 1'b0;
`endif

  // Loading is only allowed while idle so the queue never changes under playback
  assign ld_rdy       = ~busy_q & (qcnt_q != CW'(DEPTH));
  assign wr_en_d      = ld_vld & ld_rdy;
  assign rd_ptr_inc_d = rd_ptr_q + PW'(1);

  // Queue storage; occupancy is tracked by the pointers so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_ptr_q] <= ld_cmd;
    end
  end

  // Playback FSM, queue pointers and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      qcnt_q     <= '0;
      pop_q      <= '0;
      tmo_q      <= '0;
      lim_q      <= '0;
      cmd_q      <= '0;
      snd_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= ERR_OK;
      fail_idx_q <= '0;
`ifdef CMD_SEQ_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else if (abort && state_q != IDLE && state_q != FIN) begin
      // Abort beats any response, timeout or strobe arriving in the same cycle
      snd_q      <= 1'b0;
      err_q      <= ERR_ABORT;
      pass_q     <= 1'b0;
      fail_idx_q <= pop_q;
      rd_ptr_q   <= wr_ptr_q;
      qcnt_q     <= '0;
      done_q     <= 1'b1;
      state_q    <= FIN;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en_d) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
          end
          qcnt_q <= qcnt_q + CW'(wr_en_d);
          if (start) begin
            busy_q     <= 1'b1;
            lim_q      <= tmo_lim;
            pop_q      <= '0;
            err_q      <= ERR_OK;
            fail_idx_q <= '0;
`ifdef CMD_SEQ_RETRY_EN
            retry_q    <= 1'b0;
`endif
            if (qcnt_q != '0) begin
              pass_q  <= 1'b0;
              cmd_q   <= mem_q[rd_ptr_q];
              snd_q   <= 1'b1;
              state_q <= SEND;
            end else begin
              // Nothing to play: an empty list trivially passes
              pass_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end

        SEND: begin
          snd_q   <= 1'b0;
          state_q <= WAIT_SNT;
        end

        WAIT_SNT: begin
          if (cmd_snt) begin
            tmo_q   <= '0;
            state_q <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (resp_rdy && resp == ACK) begin
            state_q <= NEXT;
          end else if (resp_rdy || tmo_q == lim_q) begin
            // A response in the timeout cycle is judged on its value, not as a timeout
            if (retry_ok_d) begin
`ifdef CMD_SEQ_RETRY_EN
              retry_q <= 1'b1;
`endif
              snd_q   <= 1'b1;
              state_q <= SEND;
            end else begin
              err_q      <= resp_rdy ? ERR_NACK : ERR_TMO;
              fail_idx_q <= pop_q;
              rd_ptr_q   <= wr_ptr_q;
              qcnt_q     <= '0;
              done_q     <= 1'b1;
              state_q    <= FIN;
            end
          end
        end

        NEXT: begin
          rd_ptr_q <= rd_ptr_inc_d;
          qcnt_q   <= qcnt_q - CW'(1);
          pop_q    <= pop_q + PW'(1);
`ifdef CMD_SEQ_RETRY_EN
          retry_q  <= 1'b0;
`endif
          if (qcnt_q == CW'(1)) begin
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cmd_q   <= mem_q[rd_ptr_inc_d];
            snd_q   <= 1'b1;
            state_q <= SEND;
          end
        end

        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd      = cmd_q;
  assign snd_cmd  = snd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err      = err_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_cmd_seq_player.sv
// Directed bench for cmd_seq_player: reset, ordered playback, nack, timeout,
// full queue, abort priority, empty start and mid-playback reset.
module tb_cmd_seq_player;

  localparam int         DEPTH = 8;
  localparam int         TMO_W = 24;
  localparam logic [7:0] ACK   = 8'hA5;
`ifdef CMD_SEQ_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_vld;
  logic [15:0]      ld_cmd;
  logic             ld_rdy;
  logic             start;
  logic             abort;
  logic [TMO_W-1:0] tmo_lim;
  logic [15:0]      cmd;
  logic             snd_cmd;
  logic             cmd_snt;
  logic             resp_rdy;
  logic [7:0]       resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       err;
  logic [2:0]       fail_idx;

  int checks = 0;
  int errors = 0;

  cmd_seq_player #(.DEPTH(DEPTH), .TMO_W(TMO_W), .ACK(ACK)) dut (
    .clk(clk), .rst(rst), .ld_vld(ld_vld), .ld_cmd(ld_cmd), .ld_rdy(ld_rdy),
    .start(start), .abort(abort), .tmo_lim(tmo_lim), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
    .pass(pass), .err(err), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [15:0] c);
    ld_vld = 1'b1;
    ld_cmd = c;
    tick();
    ld_vld = 1'b0;
  endtask

  task automatic start_play();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the SEND cycle: completes transmission and returns a response byte
  task automatic run_cmd(input logic [7:0] r);
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    resp_rdy = 1'b1;
    resp = r;
    tick();
    resp_rdy = 1'b0;
    resp = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, pass, err, snd_cmd, fail_idx} !== 8'd0 || cmd !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b pass=%b err=%0d snd=%b fidx=%0d cmd=%h want all 0",
               busy, done, pass, err, snd_cmd, fail_idx, cmd);
    end
    checks++;
    if (ld_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ld_rdy got %b want 1", ld_rdy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    tmo_lim = 24'd50;
    load(16'h2000);
    load(16'h7030);
    start_play();
    checks++;
    if (snd_cmd !== 1'b1 || cmd !== 16'h2000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_send got snd=%b cmd=%h busy=%b want 1 2000 1", snd_cmd, cmd, busy);
    end
    run_cmd(ACK);
    checks++;
    if (snd_cmd !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_1 got snd=%b want 0", snd_cmd);
    end
    tick();
    checks++;
    if (snd_cmd !== 1'b1 || cmd !== 16'h7030) begin
      errors++;
      $display("FAIL basic_second_send got snd=%b cmd=%h want 1 7030", snd_cmd, cmd);
    end
    tick();
    checks++;
    if (snd_cmd !== 1'b0) begin
      errors++;
      $display("FAIL basic_snd_one_cycle got snd=%b want 0", snd_cmd);
    end
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    resp_rdy = 1'b1;
    resp = ACK;
    tick();
    resp_rdy = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err !== 2'd0) begin
      errors++;
      $display("FAIL basic_done got done=%b pass=%b err=%0d want 1 1 0", done, pass, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle got done=%b busy=%b pass=%b want 0 0 1", done, busy, pass);
    end
  endtask

  task automatic test_nack();
    do_reset();
    tmo_lim = 24'd50;
    load(16'h1111);
    load(16'h2222);
    load(16'h3333);
    start_play();
    run_cmd(ACK);
    tick();
    checks++;
    if (snd_cmd !== 1'b1 || cmd !== 16'h2222) begin
      errors++;
      $display("FAIL nack_second_send got snd=%b cmd=%h want 1 2222", snd_cmd, cmd);
    end
    run_cmd(8'h5A);
`ifdef CMD_SEQ_RETRY_EN
    checks++;
    if (snd_cmd !== 1'b1 || cmd !== 16'h2222 || err !== 2'd0) begin
      errors++;
      $display("FAIL nack_retry got snd=%b cmd=%h err=%0d want 1 2222 0", snd_cmd, cmd, err);
    end
    run_cmd(8'h5A);
`endif
    checks++;
    if (done !== 1'b1 || err !== 2'd2 || fail_idx !== 3'd1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL nack_result got done=%b err=%0d fidx=%0d pass=%b want 1 2 1 0",
               done, err, fail_idx, pass);
    end
    tick();
    // A flushed queue plays as empty: straight to FIN with pass and no send
    start_play();
    checks++;
    if (snd_cmd !== 1'b0 || done !== 1'b1 || pass !== 1'b1 || err !== 2'd0) begin
      errors++;
      $display("FAIL nack_flushed got snd=%b done=%b pass=%b err=%0d want 0 1 1 0",
               snd_cmd, done, pass, err);
    end
    tick();
  endtask

  task automatic timeout_run(input logic [TMO_W-1:0] lim, input int exp_n);
    int n;
    do_reset();
    tmo_lim = lim;
    load(16'h4242);
    start_play();
    // Changing the limit after start must not matter
    tmo_lim = 24'd5000;
    for (int a = 0; a < ATTEMPTS; a++) begin
      tick();
      cmd_snt = 1'b1;
      tick();
      cmd_snt = 1'b0;
      n = 0;
      while (done !== 1'b1 && snd_cmd !== 1'b1 && n < 300) begin
        tick();
        n++;
      end
      checks++;
      if (n !== exp_n) begin
        errors++;
        $display("FAIL tmo_latency lim=%0d attempt=%0d got %0d cycles want %0d", lim, a, n, exp_n);
      end
      if (a < ATTEMPTS - 1) begin
        checks++;
        if (snd_cmd !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL tmo_resend got snd=%b done=%b want 1 0", snd_cmd, done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || err !== 2'd1 || fail_idx !== 3'd0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL tmo_result lim=%0d got done=%b err=%0d fidx=%0d pass=%b want 1 1 0 0",
               lim, done, err, fail_idx, pass);
    end
    tick();
  endtask

  task automatic test_timeout();
    timeout_run(24'd100, 101);
    timeout_run(24'd0, 1);
  endtask

  task automatic test_full();
    do_reset();
    tmo_lim = 24'd50;
    for (int i = 0; i < DEPTH; i++) begin
      load(16'h1000 + 16'(i));
    end
    checks++;
    if (ld_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_ld_rdy got %b want 0", ld_rdy);
    end
    load(16'hDEAD);
    start_play();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (snd_cmd !== 1'b1 || cmd !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL full_send_%0d got snd=%b cmd=%h want 1 %h", i, snd_cmd, cmd, 16'h1000 + 16'(i));
      end
      run_cmd(ACK);
      tick();
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || snd_cmd !== 1'b0) begin
      errors++;
      $display("FAIL full_done got done=%b pass=%b snd=%b want 1 1 0", done, pass, snd_cmd);
    end
    tick();
    start_play();
    checks++;
    if (snd_cmd !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL full_extra_dropped got snd=%b done=%b want 0 1", snd_cmd, done);
    end
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    tmo_lim = 24'd50;
    load(16'hA001);
    load(16'hA002);
    start_play();
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    abort = 1'b1;
    resp_rdy = 1'b1;
    resp = ACK;
    tick();
    abort = 1'b0;
    resp_rdy = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 2'd3 || pass !== 1'b0 || fail_idx !== 3'd0) begin
      errors++;
      $display("FAIL abort_result got done=%b err=%0d pass=%b fidx=%0d want 1 3 0 0",
               done, err, pass, fail_idx);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 2'd3 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold got busy=%b err=%0d done=%b want 0 3 0", busy, err, done);
    end
    start_play();
    tick();
    checks++;
    if (pass !== 1'b1 || err !== 2'd0 || snd_cmd !== 1'b0) begin
      errors++;
      $display("FAIL empty_start got pass=%b err=%0d snd=%b want 1 0 0", pass, err, snd_cmd);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    do_reset();
    tmo_lim = 24'd50;
    load(16'hBEEF);
    start_play();
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, pass, err, snd_cmd, fail_idx} !== 8'd0 || cmd !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got busy=%b done=%b pass=%b err=%0d snd=%b fidx=%0d cmd=%h want all 0",
               busy, done, pass, err, snd_cmd, fail_idx, cmd);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      resp_rdy = (i == 0);
      resp = ACK;
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    resp_rdy = 1'b0;
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_done got activity=%b want 0", seen_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    ld_vld = 1'b0;
    ld_cmd = 16'h0;
    start = 1'b0;
    abort = 1'b0;
    tmo_lim = '0;
    cmd_snt = 1'b0;
    resp_rdy = 1'b0;
    resp = 8'h00;
    test_reset();
    test_basic();
    test_nack();
    test_timeout();
    test_full();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
